// File: rtl/calculator1.sv
// Keypad accumulator with 7-segment entry display and an optional HD44780 LCD writer.
// Define CALC_LCD_EN to build the LCD controller; otherwise the LCD outputs are tied low.
module calculator1 #(
    parameter int LCD_DIV        = 50,
    parameter int LCD_INIT_STEPS = 1000
) (
    input  logic       sw1,
    input  logic       sw2,
    input  logic       sw3,
    input  logic       sw4,
    input  logic       sw5,
    input  logic       sw6,
    input  logic       sw7,
    input  logic       sw8,
    input  logic       sw9,
    input  logic       rst,
    input  logic       sw0,
    input  logic       lrd,
    input  logic       clk,
    output logic [3:0] led,
    output logic [7:0] seg,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    // Bit 10 is the add key, bits 9..0 are the digit keys.
    logic [10:0] key_raw;
    logic [10:0] sync1, sync2, prev;
    logic [10:0] ev;
    logic        dig_hit;
    logic [3:0]  dig_val;
    logic [3:0]  entry;
    logic [7:0]  acc;

    assign key_raw = {lrd, sw9, sw8, sw7, sw6, sw5, sw4, sw3, sw2, sw1, sw0};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign ev = sync2 & ~prev;

    // Scan from the top so the lowest-numbered digit is the last assignment.
    always_comb begin
        dig_hit = 1'b0;
        dig_val = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (ev[i]) begin
                dig_hit = 1'b1;
                dig_val = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry <= 4'd0;
            acc   <= 8'd0;
        end else begin
            if (ev[10]) acc <= acc + {4'd0, entry};
            if (dig_hit) entry <= dig_val;
        end
    end

    assign led = entry;

    always_comb begin
        case (entry)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = 8'h00;
        endcase
    end

`ifdef CALC_LCD_EN
    localparam int TW = $clog2(LCD_DIV);
    localparam int IW = $clog2(LCD_INIT_STEPS + 16) + 1;

    typedef enum logic [3:0] {
        S_WAIT, S_FSET, S_DON, S_EMODE, S_CLR,
        S_L1CMD, S_L1DAT, S_L2CMD, S_L2DAT
    } lcd_state_t;

    lcd_state_t      state, state_n;
    logic [TW-1:0]   tick;
    logic [IW-1:0]   idx, idx_n;
    logic [4:0]      ci;
    logic            step_end;
    logic            rs_n;
    logic [7:0]      byte_n;
    logic [3:0]      hund, tens, ones;

    assign hund = 4'(acc / 8'd100);
    assign tens = 4'((acc % 8'd100) / 8'd10);
    assign ones = 4'(acc % 8'd10);

    assign step_end = (tick == TW'(LCD_DIV - 1));
    assign ci       = idx_n[4:0];

    always_comb begin
        state_n = state;
        idx_n   = idx;
        if (step_end) begin
            case (state)
                S_WAIT: begin
                    if (idx == IW'(LCD_INIT_STEPS - 1)) begin
                        state_n = S_FSET;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
                S_FSET:  state_n = S_DON;
                S_DON:   state_n = S_EMODE;
                S_EMODE: state_n = S_CLR;
                S_CLR:   state_n = S_L1CMD;
                S_L1CMD: begin
                    state_n = S_L1DAT;
                    idx_n   = '0;
                end
                S_L1DAT: begin
                    if (idx == IW'(15)) state_n = S_L2CMD;
                    idx_n = (idx == IW'(15)) ? '0 : idx + 1'b1;
                end
                S_L2CMD: begin
                    state_n = S_L2DAT;
                    idx_n   = '0;
                end
                S_L2DAT: begin
                    if (idx == IW'(15)) state_n = S_L1CMD;
                    idx_n = (idx == IW'(15)) ? '0 : idx + 1'b1;
                end
                default: begin
                    state_n = S_WAIT;
                    idx_n   = '0;
                end
            endcase
        end
    end

    // Bus value for the step about to start; sampled once so it holds for the whole step.
    always_comb begin
        rs_n   = (state_n == S_L1DAT) || (state_n == S_L2DAT);
        byte_n = 8'h00;
        case (state_n)
            S_FSET:  byte_n = 8'h38;
            S_DON:   byte_n = 8'h0C;
            S_EMODE: byte_n = 8'h06;
            S_CLR:   byte_n = 8'h01;
            S_L1CMD: byte_n = 8'h80;
            S_L2CMD: byte_n = 8'hC0;
            S_L1DAT: begin
                case (ci)
                    5'd0:    byte_n = 8'h49;
                    5'd1:    byte_n = 8'h4E;
                    5'd2:    byte_n = 8'h3A;
                    5'd3:    byte_n = 8'h30 + {4'd0, entry};
                    default: byte_n = 8'h20;
                endcase
            end
            S_L2DAT: begin
                case (ci)
                    5'd0:    byte_n = 8'h53;
                    5'd1:    byte_n = 8'h55;
                    5'd2:    byte_n = 8'h4D;
                    5'd3:    byte_n = 8'h3A;
                    5'd4:    byte_n = 8'h30 + {4'd0, hund};
                    5'd5:    byte_n = 8'h30 + {4'd0, tens};
                    5'd6:    byte_n = 8'h30 + {4'd0, ones};
                    default: byte_n = 8'h20;
                endcase
            end
            default: byte_n = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_WAIT;
            idx      <= '0;
            tick     <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            tick <= step_end ? '0 : tick + 1'b1;
            if (step_end) begin
                state    <= state_n;
                idx      <= idx_n;
                lcd_rs   <= rs_n;
                lcd_data <= byte_n;
            end
        end
    end

    assign lcd_e  = (state != S_WAIT) && (tick >= TW'(1)) && (tick <= TW'(LCD_DIV / 2 - 1));
    assign lcd_rw = 1'b0;
`else
    assign lcd_e    = 1'b0;
    assign lcd_rs   = 1'b0;
    assign lcd_rw   = 1'b0;
    assign lcd_data = 8'h00;
`endif

endmodule

// File: tb/tb_calculator1.sv
// Self-checking bench for calculator1: keypad vector table, accumulator wrap and LCD byte stream.
module tb_calculator1;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sw;
  logic       lrd;
  logic [3:0] led;
  logic [7:0] seg;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  calculator1 #(.LCD_DIV(4), .LCD_INIT_STEPS(2)) dut (
    .sw1(sw[1]), .sw2(sw[2]), .sw3(sw[3]), .sw4(sw[4]), .sw5(sw[5]),
    .sw6(sw[6]), .sw7(sw[7]), .sw8(sw[8]), .sw9(sw[9]),
    .rst(rst), .sw0(sw[0]), .lrd(lrd), .clk(clk),
    .led(led), .seg(seg),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]  exp_q[$];
  logic [11:0] kp_q[$];
  bit          sum_arm  = 1'b0;
  bit          rw_bad   = 1'b0;
  bit          e_prev   = 1'b0;
  int          e_pulses = 0;
  int          model_acc;

  typedef struct {
    logic [9:0] keys;
    logic       add;
    logic [3:0] exp_led;
    logic [7:0] exp_seg;
    logic [7:0] exp_acc;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({1'b1, s[i]});
  endtask

  task automatic press(input logic [9:0] k, input logic a);
    @(negedge clk);
    sw  = k;
    lrd = a;
    repeat (4) @(posedge clk);
    @(negedge clk);
    sw  = '0;
    lrd = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_lcd(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || sum_arm) && n < limit) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() > 0 || sum_arm) begin
      n_fail++;
      $display("FAIL lcd_timeout: %0d bytes still pending after %0d cycles", exp_q.size(), limit);
    end
  endtask

  // Byte monitor: a falling lcd_e marks one transferred byte.
  always @(negedge clk) begin
    logic [8:0] exp_b;
    if (lcd_rw !== 1'b0) rw_bad = 1'b1;
    if (!rst && e_prev && !lcd_e) begin
      e_pulses++;
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        check("lcd_byte", 32'({lcd_rs, lcd_data}), 32'(exp_b));
      end else if (sum_arm && {lcd_rs, lcd_data} == 9'h0C0) begin
        push_str("SUM:");
        exp_q.push_back({1'b1, 8'h30 + 8'(model_acc / 100)});
        exp_q.push_back({1'b1, 8'h30 + 8'((model_acc % 100) / 10)});
        exp_q.push_back({1'b1, 8'h30 + 8'(model_acc % 10)});
        sum_arm = 1'b0;
      end
    end
    e_prev = lcd_e;
  end

  initial begin
    logic [11:0] kp;

    vecs[0]  = '{10'h080, 1'b0, 4'd7, 8'h07, 8'd0};
    vecs[1]  = '{10'h108, 1'b0, 4'd3, 8'h4F, 8'd0};
    vecs[2]  = '{10'h000, 1'b1, 4'd3, 8'h4F, 8'd3};
    vecs[3]  = '{10'h001, 1'b0, 4'd0, 8'h3F, 8'd3};
    vecs[4]  = '{10'h002, 1'b0, 4'd1, 8'h06, 8'd3};
    vecs[5]  = '{10'h004, 1'b1, 4'd2, 8'h5B, 8'd4};
    vecs[6]  = '{10'h010, 1'b0, 4'd4, 8'h66, 8'd4};
    vecs[7]  = '{10'h240, 1'b0, 4'd6, 8'h7D, 8'd4};
    vecs[8]  = '{10'h3FF, 1'b0, 4'd0, 8'h3F, 8'd4};
    vecs[9]  = '{10'h100, 1'b0, 4'd8, 8'h7F, 8'd4};
    vecs[10] = '{10'h000, 1'b1, 4'd8, 8'h7F, 8'd12};
    vecs[11] = '{10'h200, 1'b0, 4'd9, 8'h6F, 8'd12};
    vecs[12] = '{10'h000, 1'b1, 4'd9, 8'h6F, 8'd21};

    // Reset state
    sw  = '0;
    lrd = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_led", 32'(led), 0);
    check("rst_seg", 32'(seg), 32'h3F);
    check("rst_lcd_e", 32'(lcd_e), 0);
    check("rst_lcd_rw", 32'(lcd_rw), 0);
    check("rst_lcd_data", 32'(lcd_data), 0);

`ifdef CALC_LCD_EN
    push_cmd(8'h38); push_cmd(8'h0C); push_cmd(8'h06); push_cmd(8'h01); push_cmd(8'h80);
    push_str("IN:0");
    rst = 1'b0;
    wait_lcd(400);
    check("lcd_e_pulses", 32'(e_pulses), 9);
`else
    rst = 1'b0;
    repeat (60) @(negedge clk);
`endif

    // Single press: update lands on the 3rd edge, then holds
    @(negedge clk);
    sw[5] = 1'b1;
    @(posedge clk); @(negedge clk);
    check("sw5_edge1_led", 32'(led), 0);
    @(posedge clk); @(negedge clk);
    check("sw5_edge2_led", 32'(led), 0);
    @(posedge clk); @(negedge clk);
    check("sw5_edge3_led", 32'(led), 5);
    check("sw5_edge3_seg", 32'(seg), 32'h6D);
    repeat (27) @(negedge clk);
    check("sw5_hold_led", 32'(led), 5);
    check("sw5_acc", 32'(dut.acc), 0);
    sw = '0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      kp_q.push_back({vecs[i].exp_led, vecs[i].exp_seg});
      press(vecs[i].keys, vecs[i].add);
      kp = kp_q.pop_front();
      check($sformatf("vec%0d_led", i), 32'(led), 32'(kp[11:8]));
      check($sformatf("vec%0d_seg", i), 32'(seg), 32'(kp[7:0]));
      check($sformatf("vec%0d_acc", i), 32'(dut.acc), 32'(vecs[i].exp_acc));
    end

`ifndef CALC_LCD_EN
    for (int i = 0; i < 5; i++) begin
      repeat (37) @(negedge clk);
      check("lcd_off", 32'({lcd_e, lcd_rs, lcd_rw, lcd_data}), 0);
    end
`endif

    // Accumulator wrap: 29 adds of 9 from zero
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_acc = 0;
    press(10'h200, 1'b0);
    for (int i = 0; i < 29; i++) begin
      press(10'h000, 1'b1);
      model_acc = (model_acc + 9) % 256;
    end
    check("wrap_acc", 32'(dut.acc), 32'(model_acc));
    check("wrap_led", 32'(led), 9);
`ifdef CALC_LCD_EN
    sum_arm = 1'b1;
    wait_lcd(2000);
`endif

    // Reset mid-step with a key already held
    repeat (7) @(negedge clk);
    rst   = 1'b1;
    sw[4] = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_lcd_e", 32'(lcd_e), 0);
    check("abort_lcd_rs", 32'(lcd_rs), 0);
    check("abort_lcd_data", 32'(lcd_data), 0);
    check("abort_led", 32'(led), 0);
`ifdef CALC_LCD_EN
    push_cmd(8'h38); push_cmd(8'h0C); push_cmd(8'h06); push_cmd(8'h01); push_cmd(8'h80);
    push_str("IN:4");
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("held_key_led", 32'(led), 4);
    check("held_key_seg", 32'(seg), 32'h66);
`ifdef CALC_LCD_EN
    wait_lcd(400);
`endif
    sw = '0;
    repeat (4) @(negedge clk);

    check("lcd_rw_const", 32'(rw_bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
